qrd_row_feeder: RTL

- Input-side transmitter for the QRD core: accepts one 4x5 complex frame `[H | y]` as a serial valid/ready stream of 20 samples and buffers it.
- Replays the frame as the four skewed row streams, with first-element flags, that the QRD systolic array consumes.
- Sits between the upstream channel-estimate source and the QRD core, replacing bench-side row scheduling.

---
 rtl/qrd_pkg.sv | 30 +++
 rtl/qrd_row_lane.sv | 32 +++
 rtl/qrd_row_feeder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/qrd_pkg.sv
// rtl/qrd_pkg.sv - shared constants, state type and row-offset helper for the QRD row feeder
package qrd_pkg;
    localparam int H_SIZE     = 4;
    localparam int ROW_LEN    = H_SIZE + 1;
    localparam int N_SAMPLES  = H_SIZE * ROW_LEN;
    localparam int ROW2_START = 1;
    localparam int ROW3_START = 21;
    localparam int ROW4_START = 41;
    localparam int F1_T       = 0;
    localparam int F2_T       = 2;
    localparam int F3_T       = 23;
    localparam int FRAME_LEN  = 46;
    localparam int T_W        = 6;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    function automatic int row_start(input int r);
        case (r)
            0:       return 0;
            1:       return ROW2_START;
            2:       return ROW3_START;
            default: return ROW4_START;
        endcase
    endfunction
endpackage

// File: rtl/qrd_row_lane.sv
// rtl/qrd_row_lane.sv - selects one buffered row element for frame cycle t, zero outside the row window
module qrd_row_lane
    import qrd_pkg::*;
#(
    parameter int IN_WIDTH = 14,
    parameter int START    = 0
) (
    input  logic                        active,
    input  logic [T_W-1:0]              t,
    input  logic [ROW_LEN*IN_WIDTH-1:0] row_r,
    input  logic [ROW_LEN*IN_WIDTH-1:0] row_i,
    output logic [IN_WIDTH-1:0]         lane_r,
    output logic [IN_WIDTH-1:0]         lane_i
);
    logic [T_W-1:0] off;

    // t below START wraps to a large offset, so one equality scan covers the window test
    assign off = t - T_W'(START);

    always_comb begin
        lane_r = '0;
        lane_i = '0;
        if (active) begin
            for (int k = 0; k < ROW_LEN; k++) begin
                if (off == T_W'(k)) begin
                    lane_r = row_r[k*IN_WIDTH +: IN_WIDTH];
                    lane_i = row_i[k*IN_WIDTH +: IN_WIDTH];
                end
            end
        end
    end
endmodule

// File: rtl/qrd_row_feeder.sv
// rtl/qrd_row_feeder.sv - buffers one 4x5 [H|y] frame and replays it as skewed row streams for the QRD array
module qrd_row_feeder
    import qrd_pkg::*;
#(
    parameter int IN_WIDTH = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_r,
    input  logic [IN_WIDTH-1:0] in_i,
    input  logic                qrd_ready,
    output logic [IN_WIDTH-1:0] row_in_1_r,
    output logic [IN_WIDTH-1:0] row_in_1_i,
    output logic [IN_WIDTH-1:0] row_in_2_r,
    output logic [IN_WIDTH-1:0] row_in_2_i,
    output logic [IN_WIDTH-1:0] row_in_3_r,
    output logic [IN_WIDTH-1:0] row_in_3_i,
    output logic [IN_WIDTH-1:0] row_in_4_r,
    output logic [IN_WIDTH-1:0] row_in_4_i,
    output logic                row_in_1_f,
    output logic                row_in_2_f,
    output logic                row_in_3_f,
    output logic                frame_start,
    output logic                frame_done
);
    state_t               state, next_state;
    logic [CNT_W-1:0]     cnt, next_cnt;
    logic [T_W-1:0]       t, next_t;
    logic                 accept;
    logic                 send_next;
    logic [IN_WIDTH-1:0]  buf_r [N_SAMPLES];
    logic [IN_WIDTH-1:0]  buf_i [N_SAMPLES];
    logic [ROW_LEN*IN_WIDTH-1:0] row_r [H_SIZE];
    logic [ROW_LEN*IN_WIDTH-1:0] row_i [H_SIZE];
    logic [IN_WIDTH-1:0]  lane_r [H_SIZE];
    logic [IN_WIDTH-1:0]  lane_i [H_SIZE];
    logic                 f1_next, f2_next, f3_next, start_next, done_next, ready_next;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
            t     <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            t     <= next_t;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_t     = t;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (cnt == CNT_W'(N_SAMPLES - 1)) begin
                        next_cnt   = '0;
                        next_state = WAIT;
                    end else begin
                        next_cnt = cnt + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (qrd_ready) begin
                    next_state = SEND;
                    next_t     = '0;
                end
            end
            SEND: begin
                if (t == T_W'(FRAME_LEN - 1)) begin
                    next_state = LOAD;
                    next_t     = '0;
                end else begin
                    next_t = t + 1'b1;
                end
            end
            default: next_state = LOAD;
        endcase
    end

    // Row-major storage: sample n lands at row n/5, column n%5
    always_ff @(posedge clk) begin
        if (accept && state == LOAD) begin
            buf_r[cnt] <= in_r;
            buf_i[cnt] <= in_i;
        end
    end

    for (genvar j = 0; j < H_SIZE; j++) begin : g_pack
        for (genvar k = 0; k < ROW_LEN; k++) begin : g_col
            assign row_r[j][k*IN_WIDTH +: IN_WIDTH] = buf_r[j*ROW_LEN+k];
            assign row_i[j][k*IN_WIDTH +: IN_WIDTH] = buf_i[j*ROW_LEN+k];
        end
    end

    // Lanes look at the next frame cycle so the registered outputs line up with t
    assign send_next = (next_state == SEND);

    for (genvar r = 0; r < H_SIZE; r++) begin : g_lane
        qrd_row_lane #(
            .IN_WIDTH (IN_WIDTH),
            .START    (row_start(r))
        ) u_lane (
            .active (send_next),
            .t      (next_t),
            .row_r  (row_r[r]),
            .row_i  (row_i[r]),
            .lane_r (lane_r[r]),
            .lane_i (lane_i[r])
        );
    end

    always_comb begin
        f1_next    = send_next && (next_t == T_W'(F1_T));
        f2_next    = send_next && (next_t == T_W'(F2_T));
        f3_next    = send_next && (next_t == T_W'(F3_T));
        start_next = send_next && (next_t == T_W'(0));
        done_next  = send_next && (next_t == T_W'(FRAME_LEN - 1));
        ready_next = (next_state == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready    <= 1'b1;
            row_in_1_r  <= '0;
            row_in_1_i  <= '0;
            row_in_2_r  <= '0;
            row_in_2_i  <= '0;
            row_in_3_r  <= '0;
            row_in_3_i  <= '0;
            row_in_4_r  <= '0;
            row_in_4_i  <= '0;
            row_in_1_f  <= 1'b0;
            row_in_2_f  <= 1'b0;
            row_in_3_f  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            in_ready    <= ready_next;
            row_in_1_r  <= lane_r[0];
            row_in_1_i  <= lane_i[0];
            row_in_2_r  <= lane_r[1];
            row_in_2_i  <= lane_i[1];
            row_in_3_r  <= lane_r[2];
            row_in_3_i  <= lane_i[2];
            row_in_4_r  <= lane_r[3];
            row_in_4_i  <= lane_i[3];
            row_in_1_f  <= f1_next;
            row_in_2_f  <= f2_next;
            row_in_3_f  <= f3_next;
            frame_start <= start_next;
            frame_done  <= done_next;
        end
    end
endmodule
